// File: rtl/load_unit_ctrl_if.sv
// Core-side load handshake and cache read port bundle for load_unit_ctrl.
// slave is the controller's view; master is the core/cache environment.
interface load_unit_ctrl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  i_ld_valid;
    logic                  o_ld_ready;
    logic [ADDR_WIDTH-1:0] i_ld_addr;
    logic [2:0]            i_ld_func_3;
    logic                  i_flush;
    logic                  o_mem_req_valid;
    logic                  i_mem_req_ready;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  i_mem_rsp_valid;
    logic [DATA_WIDTH-1:0] i_mem_rsp_data;
    logic                  i_mem_rsp_err;
    logic                  o_rsp_valid;
    logic [DATA_WIDTH-1:0] o_rsp_data;
    logic                  o_load_addr_ma;
    logic                  o_access_fault;
    logic                  o_illegal_instr;

    modport slave (
        input  i_ld_valid, i_ld_addr, i_ld_func_3, i_flush,
        input  i_mem_req_ready, i_mem_rsp_valid,
        input  i_mem_rsp_data, i_mem_rsp_err,
        output o_ld_ready, o_mem_req_valid, o_mem_addr,
        output o_rsp_valid, o_rsp_data,
        output o_load_addr_ma, o_access_fault, o_illegal_instr
    );

    modport master (
        output i_ld_valid, i_ld_addr, i_ld_func_3, i_flush,
        output i_mem_req_ready, i_mem_rsp_valid,
        output i_mem_rsp_data, i_mem_rsp_err,
        input  o_ld_ready, o_mem_req_valid, o_mem_addr,
        input  o_rsp_valid, o_rsp_data,
        input  o_load_addr_ma, o_access_fault, o_illegal_instr
    );
endinterface

// File: rtl/load_unit_ctrl.sv
// Load sequencer between memory stage and data cache, one load in flight.
// LOAD_MISALIGNED_SPLIT_EN: service misaligned loads, splitting dword crossers.
module load_unit_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic            clk,
    input  logic            i_rst,
    load_unit_ctrl_if.slave bus
);

`ifdef LOAD_MISALIGNED_SPLIT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE, S_REQ2, S_WAIT2
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE
    } state_t;
`endif

    state_t                state_q;
    logic                  ready_q;
    logic                  req_valid_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [2:0]            off_q;
    logic [2:0]            func3_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  ma_q;
    logic                  fault_q;
    logic                  ill_q;

    logic [2:0]            in_off;
    logic                  ill_d;
    logic [DATA_WIDTH-1:0] shr_d;
    logic [DATA_WIDTH-1:0] ext_d;

    assign in_off = bus.i_ld_addr[2:0];
    assign ill_d  = (bus.i_ld_func_3 == 3'b111);

`ifdef LOAD_MISALIGNED_SPLIT_EN
    logic                    cross_q;
    logic [DATA_WIDTH-1:0]   lo_q;
    logic [3:0]              size_d;
    logic                    cross_d;
    logic [2*DATA_WIDTH-1:0] cat_d;

    assign size_d  = 4'd1 << bus.i_ld_func_3[1:0];
    assign cross_d = ({1'b0, in_off} + size_d) > 4'd8;

    // second beat supplies the upper dword of the shift window
    always_comb begin
        cat_d = {{DATA_WIDTH{1'b0}}, bus.i_mem_rsp_data};
        if (state_q == S_WAIT2) begin
            cat_d = {bus.i_mem_rsp_data, lo_q};
        end
        shr_d = DATA_WIDTH'(cat_d >> {off_q, 3'b000});
    end
`else
    logic mis_d;

    always_comb begin
        mis_d = 1'b0;
        unique case (bus.i_ld_func_3[1:0])
            2'b01:   mis_d = in_off[0];
            2'b10:   mis_d = |in_off[1:0];
            2'b11:   mis_d = |in_off;
            default: mis_d = 1'b0;
        endcase
    end

    always_comb begin
        shr_d = bus.i_mem_rsp_data >> {off_q, 3'b000};
    end
`endif

    always_comb begin
        ext_d = '0;
        unique case (func3_q)
            3'b000:  ext_d = {{56{shr_d[7]}}, shr_d[7:0]};
            3'b001:  ext_d = {{48{shr_d[15]}}, shr_d[15:0]};
            3'b010:  ext_d = {{32{shr_d[31]}}, shr_d[31:0]};
            3'b011:  ext_d = shr_d;
            3'b100:  ext_d = {56'd0, shr_d[7:0]};
            3'b101:  ext_d = {48'd0, shr_d[15:0]};
            3'b110:  ext_d = {32'd0, shr_d[31:0]};
            default: ext_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            req_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            off_q       <= '0;
            func3_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ma_q        <= 1'b0;
            fault_q     <= 1'b0;
            ill_q       <= 1'b0;
`ifdef LOAD_MISALIGNED_SPLIT_EN
            cross_q     <= 1'b0;
            lo_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_ld_valid && !bus.i_flush) begin
                        off_q      <= in_off;
                        func3_q    <= bus.i_ld_func_3;
                        mem_addr_q <= {bus.i_ld_addr[ADDR_WIDTH-1:3], 3'b000};
                        ready_q    <= 1'b0;
`ifdef LOAD_MISALIGNED_SPLIT_EN
                        cross_q    <= cross_d;
`endif
                        if (ill_d) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            ill_q       <= 1'b1;
                        end
`ifndef LOAD_MISALIGNED_SPLIT_EN
                        else if (mis_d) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            ma_q        <= 1'b1;
                        end
`endif
                        else begin
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // a flush racing the handshake still owes us a response
                    if (bus.i_mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= bus.i_flush ? S_DRAIN : S_WAIT;
                    end else if (bus.i_flush) begin
                        req_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.i_mem_rsp_valid) begin
                        if (bus.i_flush) begin
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (bus.i_mem_rsp_err) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            fault_q     <= 1'b1;
                            rsp_data_q  <= '0;
                        end
`ifdef LOAD_MISALIGNED_SPLIT_EN
                        else if (cross_q) begin
                            lo_q        <= bus.i_mem_rsp_data;
                            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(8);
                            req_valid_q <= 1'b1;
                            state_q     <= S_REQ2;
                        end
`endif
                        else begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= ext_d;
                        end
                    end else if (bus.i_flush) begin
                        state_q <= S_DRAIN;
                    end
                end
`ifdef LOAD_MISALIGNED_SPLIT_EN
                S_REQ2: begin
                    if (bus.i_mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= bus.i_flush ? S_DRAIN : S_WAIT2;
                    end else if (bus.i_flush) begin
                        req_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_WAIT2: begin
                    if (bus.i_mem_rsp_valid) begin
                        if (bus.i_flush) begin
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (bus.i_mem_rsp_err) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            fault_q     <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= ext_d;
                        end
                    end else if (bus.i_flush) begin
                        state_q <= S_DRAIN;
                    end
                end
`endif
                S_DRAIN: begin
                    if (bus.i_mem_rsp_valid) begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_DONE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_data_q  <= '0;
                    ma_q        <= 1'b0;
                    fault_q     <= 1'b0;
                    ill_q       <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // flush during the result cycle cancels the pulse
    assign bus.o_rsp_valid     = rsp_valid_q & ~bus.i_flush;
    assign bus.o_ld_ready      = ready_q;
    assign bus.o_mem_req_valid = req_valid_q;
    assign bus.o_mem_addr      = mem_addr_q;
    assign bus.o_rsp_data      = rsp_data_q;
    assign bus.o_load_addr_ma  = ma_q;
    assign bus.o_access_fault  = fault_q;
    assign bus.o_illegal_instr = ill_q;

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Bench for load_unit_ctrl: directed cases plus random loads vs byte-level model.
// Cache behaviour is emulated cycle by cycle inside run_load.
module tb_load_unit_ctrl;
    logic clk = 1'b0;
    logic i_rst;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] mem [logic [63:0]];

    always #5 clk = ~clk;

    load_unit_ctrl_if bus ();

    load_unit_ctrl dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    function automatic logic [63:0] mem_dw(input logic [63:0] a);
        if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
        return mem[a];
    endfunction

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        logic [63:0] d;
        d = mem_dw({a[63:3], 3'b000});
        return d[8*a[2:0] +: 8];
    endfunction

    // little-endian gather of size bytes, then extend
    function automatic void model(
        input  logic [63:0] a,
        input  logic [2:0]  f3,
        input  logic [1:0]  errm,
        output logic [63:0] d,
        output logic        ma,
        output logic        ill,
        output logic        flt,
        output int          nb
    );
        int          sz;
        logic [63:0] v;
        sz  = 1 << f3[1:0];
        d   = '0;
        ma  = 1'b0;
        flt = 1'b0;
        nb  = 0;
        ill = (f3 == 3'b111);
        if (ill) return;
`ifdef LOAD_MISALIGNED_SPLIT_EN
        nb = ((int'(a[2:0]) + sz) > 8) ? 2 : 1;
`else
        if ((int'(a[2:0]) % sz) != 0) begin
            ma = 1'b1;
            return;
        end
        nb = 1;
`endif
        flt = errm[0] | ((nb == 2) && errm[1]);
        if (flt) return;
        v = '0;
        for (int i = 0; i < sz; i++)
            v = v | (64'(mem_byte(a + 64'(i))) << (8 * i));
        if (!f3[2] && sz < 8 && v[8*sz-1])
            v = v | ~((64'd1 << (8 * sz)) - 64'd1);
        d = v;
    endfunction

    task automatic run_load(
        input  logic [63:0] a,
        input  logic [2:0]  f3,
        input  int          req_lat,
        input  int          rsp_lat,
        input  logic [1:0]  errm,
        input  int          flush_at,
        input  int          rst_at,
        input  bit          junk,
        output int          seen,
        output int          rcyc,
        output logic [63:0] rdata,
        output logic [2:0]  rflags,
        output int          nreq,
        output logic [63:0] ra0,
        output logic [63:0] ra1,
        output int          rdy,
        output int          lastrsp,
        output int          unstable
    );
        int          wcnt;
        bit          pend;
        int          pcyc;
        int          pbeat;
        logic [63:0] paddr;
        bit          prev_req;
        logic [63:0] prev_addr;
        seen = 0; rcyc = -1; rdata = '0; rflags = '0;
        nreq = 0; ra0 = '0; ra1 = '0; rdy = -1;
        lastrsp = -1; unstable = 0;
        wcnt = 0; pend = 0; pcyc = 0; pbeat = 0;
        paddr = '0; prev_req = 0; prev_addr = '0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            bus.i_ld_valid  = (c == 0);
            bus.i_ld_addr   = a;
            bus.i_ld_func_3 = f3;
            bus.i_flush     = (c == flush_at);
            i_rst           = (c == rst_at);
            bus.i_mem_req_ready = 1'b0;
            if (bus.o_mem_req_valid) begin
                bus.i_mem_req_ready = (wcnt >= req_lat);
                wcnt++;
            end else begin
                wcnt = 0;
            end
            bus.i_mem_rsp_valid = 1'b0;
            bus.i_mem_rsp_err   = 1'b0;
            bus.i_mem_rsp_data  = {$urandom, $urandom};
            if (pend && c == pcyc) begin
                bus.i_mem_rsp_valid = 1'b1;
                bus.i_mem_rsp_data  = mem_dw(paddr);
                bus.i_mem_rsp_err   = errm[pbeat];
                pend    = 0;
                lastrsp = c;
            end else if (junk && c == 0) begin
                bus.i_mem_rsp_valid = 1'b1;
            end
            @(negedge clk);
            if (bus.o_mem_req_valid && prev_req &&
                bus.o_mem_addr !== prev_addr) unstable++;
            prev_req  = bus.o_mem_req_valid && !bus.i_mem_req_ready;
            prev_addr = bus.o_mem_addr;
            if (bus.o_mem_req_valid && bus.i_mem_req_ready) begin
                if (nreq == 0) ra0 = bus.o_mem_addr;
                else ra1 = bus.o_mem_addr;
                paddr = bus.o_mem_addr;
                pbeat = (nreq > 0) ? 1 : 0;
                nreq++;
                pend = 1;
                pcyc = c + 1 + rsp_lat;
                wcnt = 0;
            end
            if (bus.o_rsp_valid) begin
                seen++;
                rcyc   = c;
                rdata  = bus.o_rsp_data;
                rflags = {bus.o_load_addr_ma, bus.o_access_fault,
                          bus.o_illegal_instr};
            end
            if (c >= 1 && bus.o_ld_ready && !pend) begin
                rdy = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        bus.i_ld_valid = 0; bus.i_ld_addr = '0;
        bus.i_ld_func_3 = '0; bus.i_flush = 0;
        bus.i_mem_req_ready = 0; bus.i_mem_rsp_valid = 0;
        bus.i_mem_rsp_data = '0; bus.i_mem_rsp_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got=%b exp=1", bus.o_ld_ready);
        end
        checks++;
        if (bus.o_mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_req got=%b exp=0", bus.o_mem_req_valid);
        end
        checks++;
        if (bus.o_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rspv got=%b exp=0", bus.o_rsp_valid);
        end
        checks++;
        if (bus.o_rsp_data !== 64'd0) begin
            errors++;
            $display("FAIL rst_data got=%h exp=0", bus.o_rsp_data);
        end
        checks++;
        if ({bus.o_load_addr_ma, bus.o_access_fault,
             bus.o_illegal_instr} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags got=%b%b%b exp=000",
                     bus.o_load_addr_ma, bus.o_access_fault,
                     bus.o_illegal_instr);
        end
        @(posedge clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic test_directed();
        int seen, rcyc, nreq, rdy, lr, un;
        logic [63:0] rd, a0, a1;
        logic [2:0]  fl;
        mem[64'h1000] = 64'h0000_0000_8000_0000;
        run_load(64'h1003, 3'b000, 0, 0, 2'b00, -1, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (a0 !== 64'h1000) begin
            errors++; $display("FAIL lb_addr got=%h exp=1000", a0);
        end
        checks++;
        if (seen !== 1 || rd !== 64'hFFFF_FFFF_FFFF_FF80) begin
            errors++;
            $display("FAIL lb_data got=%h n=%0d exp=ffffffffffffff80",
                     rd, seen);
        end
        mem[64'h2000] = 64'h8765_4321_0000_0000;
        run_load(64'h2004, 3'b110, 0, 0, 2'b00, -1, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (rd !== 64'h8765_4321) begin
            errors++; $display("FAIL lwu_data got=%h exp=87654321", rd);
        end
        checks++;
        if (rcyc !== 3) begin
            errors++; $display("FAIL lwu_cycle got=%0d exp=3", rcyc);
        end
`ifdef LOAD_MISALIGNED_SPLIT_EN
        mem[64'h5000] = 64'hBBAA_0000_0000_0000;
        mem[64'h5008] = 64'h0000_0000_0000_DDCC;
        run_load(64'h5006, 3'b010, 0, 0, 2'b00, -1, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (nreq !== 2 || a0 !== 64'h5000 || a1 !== 64'h5008) begin
            errors++;
            $display("FAIL split_addr got=%0d %h %h exp=2 5000 5008",
                     nreq, a0, a1);
        end
        checks++;
        if (rd !== 64'hFFFF_FFFF_DDCC_BBAA || fl !== 3'b000) begin
            errors++;
            $display("FAIL split_data got=%h f=%b exp=ffffffffddccbbaa",
                     rd, fl);
        end
`else
        run_load(64'h3001, 3'b001, 0, 0, 2'b00, -1, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (fl !== 3'b100 || rd !== 64'd0 || rcyc !== 1) begin
            errors++;
            $display("FAIL lh_ma got=f%b d=%h c=%0d exp=f100 d=0 c=1",
                     fl, rd, rcyc);
        end
        checks++;
        if (nreq !== 0) begin
            errors++; $display("FAIL lh_ma_req got=%0d exp=0", nreq);
        end
`endif
        run_load(64'h3000, 3'b111, 0, 0, 2'b00, -1, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (fl !== 3'b001 || rcyc !== 1 || nreq !== 0) begin
            errors++;
            $display("FAIL illegal got=f%b c=%0d r=%0d exp=f001 c=1 r=0",
                     fl, rcyc, nreq);
        end
        run_load(64'h40, 3'b011, 0, 0, 2'b01, -1, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (fl !== 3'b010 || rd !== 64'd0 || seen !== 1) begin
            errors++;
            $display("FAIL fault got=f%b d=%h n=%0d exp=f010 d=0 n=1",
                     fl, rd, seen);
        end
    endtask

    task automatic test_flush();
        int seen, rcyc, nreq, rdy, lr, un;
        logic [63:0] rd, a0, a1;
        logic [2:0]  fl;
        run_load(64'h48, 3'b011, 0, 3, 2'b00, 2, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (seen !== 0 || lr !== 5 || rdy !== 6) begin
            errors++;
            $display("FAIL flush_wait got=n%0d r%0d y%0d exp=n0 r5 y6",
                     seen, lr, rdy);
        end
        run_load(64'h50, 3'b011, 3, 0, 2'b00, 2, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (seen !== 0 || nreq !== 0 || rdy !== 3) begin
            errors++;
            $display("FAIL flush_req got=n%0d q%0d y%0d exp=n0 q0 y3",
                     seen, nreq, rdy);
        end
        run_load(64'h58, 3'b011, 0, 0, 2'b00, 3, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (seen !== 0 || rdy !== 4) begin
            errors++;
            $display("FAIL flush_done got=n%0d y%0d exp=n0 y4",
                     seen, rdy);
        end
        run_load(64'h60, 3'b011, 0, 0, 2'b00, 0, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (seen !== 0 || nreq !== 0 || rdy !== 1) begin
            errors++;
            $display("FAIL flush_idle got=n%0d q%0d y%0d exp=n0 q0 y1",
                     seen, nreq, rdy);
        end
    endtask

    task automatic test_reset_mid();
        int seen, rcyc, nreq, rdy, lr, un;
        logic [63:0] rd, a0, a1, ed;
        logic [2:0]  fl;
        logic        ema, eill, eflt;
        int          nb;
        run_load(64'h68, 3'b011, 0, 4, 2'b00, -1, 2, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (seen !== 0 || nreq !== 1 || lr !== 6) begin
            errors++;
            $display("FAIL rst_mid got=n%0d q%0d r%0d exp=n0 q1 r6",
                     seen, nreq, lr);
        end
        model(64'h70, 3'b010, 2'b00, ed, ema, eill, eflt, nb);
        run_load(64'h70, 3'b010, 0, 0, 2'b00, -1, -1, 0,
                 seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
        checks++;
        if (seen !== 1 || rd !== ed || rcyc !== 3) begin
            errors++;
            $display("FAIL rst_after got=%h c%0d exp=%h c3", rd, rcyc, ed);
        end
    endtask

    task automatic test_back_to_back();
        int seen, rcyc, nreq, rdy, lr, un;
        int req_lat, rsp_lat, nb, eb, ecyc, t;
        logic [63:0] a, rd, a0, a1, ed;
        logic [2:0]  f3, fl;
        logic [1:0]  errm;
        logic        ema, eill, eflt;
        bit          junk;
        for (int it = 0; it < 150; it++) begin
            a = 64'h8000 + 64'($urandom_range(0, 255));
            f3 = ($urandom_range(0, 15) == 0) ? 3'b111
                 : 3'($urandom_range(0, 6));
            req_lat = $urandom_range(0, 2);
            rsp_lat = $urandom_range(0, 3);
            errm = ($urandom_range(0, 7) == 0)
                   ? 2'($urandom_range(1, 3)) : 2'b00;
            junk = 1'($urandom_range(0, 1));
            model(a, f3, errm, ed, ema, eill, eflt, nb);
            run_load(a, f3, req_lat, rsp_lat, errm, -1, -1, junk,
                     seen, rcyc, rd, fl, nreq, a0, a1, rdy, lr, un);
            eb = (nb == 2 && errm[0]) ? 1 : nb;
            t = 0;
            for (int b = 0; b < eb; b++)
                t = t + 1 + req_lat + 1 + rsp_lat;
            ecyc = t + 1;
            checks++;
            if (seen !== 1 || rcyc !== ecyc) begin
                errors++;
                $display("FAIL rnd_cycle it=%0d got=n%0d c%0d exp=n1 c%0d",
                         it, seen, rcyc, ecyc);
            end
            checks++;
            if (rd !== ed) begin
                errors++;
                $display("FAIL rnd_data it=%0d a=%h f=%0d got=%h exp=%h",
                         it, a, f3, rd, ed);
            end
            checks++;
            if (fl !== {ema, eflt, eill}) begin
                errors++;
                $display("FAIL rnd_flags it=%0d got=%b exp=%b",
                         it, fl, {ema, eflt, eill});
            end
            checks++;
            if (nreq !== eb) begin
                errors++;
                $display("FAIL rnd_nreq it=%0d got=%0d exp=%0d",
                         it, nreq, eb);
            end
            if (eb > 0) begin
                checks++;
                if (a0 !== {a[63:3], 3'b000} || un !== 0) begin
                    errors++;
                    $display("FAIL rnd_addr it=%0d got=%h u%0d exp=%h u0",
                             it, a0, un, {a[63:3], 3'b000});
                end
            end
            if (eb == 2) begin
                checks++;
                if (a1 !== {a[63:3], 3'b000} + 64'd8) begin
                    errors++;
                    $display("FAIL rnd_addr2 it=%0d got=%h exp=%h",
                             it, a1, {a[63:3], 3'b000} + 64'd8);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
